// File: rtl/arith_unit_mc_if.sv
// Request/response bundle for arith_unit_mc: operand request handshake in, result handshake out.
interface arith_unit_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (output in_valid, a, b, sel, out_ready,
                  input  in_ready, out_valid, r, dz);
  modport slave  (input  in_valid, a, b, sel, out_ready,
                  output in_ready, out_valid, r, dz);
endinterface

// File: rtl/arith_unit_mc.sv
// Multi-cycle signed ADD/SUB/MUL/DIV unit, one op in flight, registered handshake outputs.
// Define ARITH_UNIT_MC_DIV_EN to build the restoring divider; otherwise sel=3 returns r=0, dz=1.
module arith_unit_mc #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  arith_unit_mc_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] exec_r;
  logic             exec_dz;
  logic             accept;

  assign accept = bus.in_valid && bus.in_ready;

  // Single-cycle ops evaluated from the captured operands while in EXEC.
  always_comb begin
    exec_r  = '0;
    exec_dz = 1'b0;
    case (op_sel)
      OP_ADD:  exec_r = op_a + op_b;
      OP_SUB:  exec_r = op_a - op_b;
      OP_MUL:  exec_r = op_a * op_b;  // low half of signed product == low half of unsigned
      default: begin
`ifdef ARITH_UNIT_MC_DIV_EN
        exec_r  = '1;                 // only reached for divide by zero
`else
        exec_r  = '0;
`endif
        exec_dz = 1'b1;
      end
    endcase
  end

`ifdef ARITH_UNIT_MC_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic             go_div;

  // Restoring step: quo shifts its MSB into rem and collects one quotient bit at the bottom.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];
  assign go_div = (bus.sel == 2'd3) && (bus.b != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.r         <= '0;
      bus.dz        <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      op_sel        <= '0;
`ifdef ARITH_UNIT_MC_DIV_EN
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      neg           <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.in_ready <= 1'b0;
          op_a         <= bus.a;
          op_b         <= bus.b;
          op_sel       <= bus.sel;
          state        <= EXEC;
`ifdef ARITH_UNIT_MC_DIV_EN
          // Magnitudes as unsigned; most-negative maps onto itself, which is its true magnitude.
          quo <= bus.a[WIDTH-1] ? -bus.a : bus.a;
          dvs <= bus.b[WIDTH-1] ? -bus.b : bus.b;
          neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rem <= '0;
          cnt <= '0;
          if (go_div) state <= DIV;
`endif
        end
        EXEC: begin
          bus.r         <= exec_r;
          bus.dz        <= exec_dz;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
`ifdef ARITH_UNIT_MC_DIV_EN
        DIV: begin
          // WIDTH quotient-bit steps, then one sign-fixup cycle into DONE.
          if (cnt == CW'(WIDTH)) begin
            bus.r         <= neg ? -quo : quo;
            bus.dz        <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  initial assert (WIDTH >= 4);
endmodule

// File: tb/tb_arith_unit_mc.sv
// Scoreboard bench for arith_unit_mc at WIDTH=32; follows ARITH_UNIT_MC_DIV_EN if defined.
module tb_arith_unit_mc;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  arith_unit_mc_if #(.WIDTH(W)) bus ();
  arith_unit_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Independent reference: SV signed arithmetic on widened operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    exp_t e;
    logic signed [2*W-1:0] p;
    e.dz = 1'b0; e.lat = 2; e.r = '0;
    case (s)
      2'd0: e.r = a + b;
      2'd1: e.r = a - b;
      2'd2: begin p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}); e.r = p[W-1:0]; end
      default: begin
`ifdef ARITH_UNIT_MC_DIV_EN
        if (b == '0) begin e.r = '1; e.dz = 1'b1; end
        else begin
          p = $signed({{W{a[W-1]}}, a}) / $signed({{W{b[W-1]}}, b});
          e.r = p[W-1:0]; e.lat = W + 2;
        end
`else
        e.r = '0; e.dz = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic wait_ready(input string name);
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout in_ready=%b want 1", name, bus.in_ready); end
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [1:0] os,
                       input int stall, input exp_t want, input string name);
    exp_t e;
    int   k;
    wait_ready(name);
    bus.a = oa; bus.b = ob; bus.sel = os; bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    sbq.push_back(want);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!bus.out_valid && k < 100) begin @(negedge clk); k++; end
    e = sbq.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid_timeout got=%b want 1", name, bus.out_valid);
      return;
    end
    checks++;
    if (k + 1 !== e.lat) begin errors++; $display("FAIL %s latency got=%0d want=%0d", name, k + 1, e.lat); end
    checks++;
    if (bus.r !== e.r) begin errors++; $display("FAIL %s r got=%h want=%h", name, bus.r, e.r); end
    checks++;
    if (bus.dz !== e.dz) begin errors++; $display("FAIL %s dz got=%b want=%b", name, bus.dz, e.dz); end
    if (stall > 0) begin
      // Offer a different request while the result is stalled; it must be ignored.
      bus.a = ~oa; bus.b = 32'd1; bus.sel = 2'd0; bus.in_valid = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.r !== e.r || bus.dz !== e.dz || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_hold ov=%b r=%h dz=%b rdy=%b want ov=1 r=%h dz=%b rdy=0",
                   name, bus.out_valid, bus.r, bus.dz, bus.in_ready, e.r, e.dz);
        end
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s post_handshake ov=%b rdy=%b want ov=0 rdy=1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic dz, input int lat);
    exp_t e; e.r = r; e.dz = dz; e.lat = lat; return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.r !== '0 || bus.dz !== 1'b0) begin
      errors++; $display("FAIL reset rdy=%b ov=%b r=%h dz=%b want 1 0 0 0", bus.in_ready, bus.out_valid, bus.r, bus.dz);
    end
  endtask

  task automatic test_basic();
    do_op(32'd7,        -32'sd9,   2'd0, 0, mk(-32'sd2,      1'b0, 2), "add_7_m9");
    do_op(32'h8000_0000, 32'd1,    2'd1, 0, mk(32'h7FFF_FFFF, 1'b0, 2), "sub_wrap");
    do_op(32'h0001_0000, 32'h0001_0000, 2'd2, 0, mk(32'd0,   1'b0, 2), "mul_trunc");
    do_op(-32'sd3,      32'd5,     2'd2, 0, mk(-32'sd15,     1'b0, 2), "mul_m3_5");
  endtask

  task automatic test_div();
`ifdef ARITH_UNIT_MC_DIV_EN
    do_op(-32'sd7,       32'd2,  2'd3, 0, mk(-32'sd3,       1'b0, W + 2), "div_m7_2");
    do_op(32'h8000_0000, -32'sd1, 2'd3, 0, mk(32'h8000_0000, 1'b0, W + 2), "div_minneg");
    do_op(32'd100,       32'd0,  2'd3, 0, mk(32'hFFFF_FFFF, 1'b1, 2),     "div_zero");
    do_op(32'd100,       -32'sd7, 2'd3, 0, mk(-32'sd14,     1'b0, W + 2), "div_100_m7");
`else
    do_op(32'd100,       32'd5,  2'd3, 0, mk(32'd0, 1'b1, 2), "div_disabled");
`endif
  endtask

  task automatic test_stall();
    do_op(32'd20, 32'd22, 2'd0, 5, mk(32'd42, 1'b0, 2), "stall_add");
  endtask

  task automatic test_abort();
    int d;
    logic seen = 1'b0;
    wait_ready("abort");
`ifdef ARITH_UNIT_MC_DIV_EN
    bus.sel = 2'd3; bus.a = 32'd1000; bus.b = 32'd3; d = 10;
`else
    bus.sel = 2'd0; bus.a = 32'd1000; bus.b = 32'd3; d = 1;
`endif
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (d - 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want 1", bus.in_ready); end
    repeat (50) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_result out_valid seen=1 want 0"); end
    do_op(32'd1, 32'd1, 2'd0, 0, mk(32'd2, 1'b0, 2), "after_abort");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [1:0]   rs;
    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rb = $urandom; rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = '1; end
        2: rb = 32'($urandom_range(0, 15)) - 32'd8;
        default: ;
      endcase
      do_op(ra, rb, rs, $urandom_range(0, 3), model(ra, rb, rs), "random");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_div();
    test_stall();
    test_abort();
    test_random();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
